// File: rtl/ace_pkg.sv
// Shared constants and width helpers for the ACE channel monitor.
package ace_pkg;

  localparam int unsigned ACK_RACK_UDF = 0;
  localparam int unsigned ACK_RACK_OVF = 1;
  localparam int unsigned ACK_WACK_UDF = 2;
  localparam int unsigned ACK_WACK_OVF = 3;

  function automatic int unsigned pend_w(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  // Keeps the index port at least one bit wide for a single-channel build.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ace_hs_chk.sv
// Per-channel valid/ready protocol checker: payload stability, valid drop and stall timeout.
// Timeout tracking exists only when ACE_CHAN_MONITOR_TIMEOUT_EN is defined.
module ace_hs_chk #(
  parameter int unsigned PayloadWidth  = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic                    ready_i,
  input  logic [PayloadWidth-1:0] payload_i,
  output logic                    err_stable_o,
  output logic                    err_drop_o,
  output logic                    err_timeout_o,
  output logic                    err_det_o
);

  logic                    valid_q, ready_q;
  logic [PayloadWidth-1:0] payload_q;
  logic                    stable_q, drop_q;
  logic                    stall_q, stable_det, drop_det, to_det;

  // A stall last cycle obliges the source to hold valid and payload now.
  assign stall_q    = valid_q & ~ready_q;
  assign stable_det = stall_q & valid_i & (payload_i != payload_q);
  assign drop_det   = stall_q & ~valid_i;
  assign err_det_o  = stable_det | drop_det | to_det;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      payload_q <= '0;
      stable_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      valid_q   <= valid_i;
      ready_q   <= ready_i;
      payload_q <= payload_i;
      stable_q  <= (stable_q & ~clear_i) | stable_det;
      drop_q    <= (drop_q & ~clear_i) | drop_det;
    end
  end

  assign err_stable_o = stable_q;
  assign err_drop_o   = drop_q;

`ifdef ACE_CHAN_MONITOR_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TimeoutCycles + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          to_q;

  always_comb begin
    wait_d = wait_q;
    to_det = 1'b0;
    if (!valid_i || ready_i) begin
      wait_d = '0;
    end else if (wait_q != WW'(TimeoutCycles)) begin
      wait_d = wait_q + 1'b1;
      to_det = (wait_d == WW'(TimeoutCycles));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      to_q   <= (to_q & ~clear_i) | to_det;
    end
  end

  assign err_timeout_o = to_q;
`else
  assign to_det        = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

endmodule

// File: rtl/ace_chan_monitor.sv
// ACE channel monitor: per-channel handshake checks plus RACK/WACK pending-count tracking.
// Optional stall timeout enabled by ACE_CHAN_MONITOR_TIMEOUT_EN.
module ace_chan_monitor
  import ace_pkg::*;
#(
  parameter int unsigned NumChan        = 5,
  parameter int unsigned PayloadWidth   = 64,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic [NumChan-1:0]                valid_i,
  input  logic [NumChan-1:0]                ready_i,
  input  logic [NumChan*PayloadWidth-1:0]   payload_i,
  input  logic                              r_done_i,
  input  logic                              b_done_i,
  input  logic                              rack_i,
  input  logic                              wack_i,
  output logic [NumChan-1:0]                err_stable_o,
  output logic [NumChan-1:0]                err_drop_o,
  output logic [NumChan-1:0]                err_timeout_o,
  output logic [3:0]                        err_ack_o,
  output logic [pend_w(MaxOutstanding)-1:0] rack_pend_o,
  output logic [pend_w(MaxOutstanding)-1:0] wack_pend_o,
  output logic                              first_vld_o,
  output logic [idx_w(NumChan)-1:0]         first_idx_o
);

  localparam int unsigned PW = pend_w(MaxOutstanding);
  localparam int unsigned IW = idx_w(NumChan);

  logic [NumChan-1:0] det;

  for (genvar k = 0; k < NumChan; k++) begin : g_ch
    ace_hs_chk #(
      .PayloadWidth (PayloadWidth),
      .TimeoutCycles(TimeoutCycles)
    ) u_chk (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .valid_i      (valid_i[k]),
      .ready_i      (ready_i[k]),
      .payload_i    (payload_i[k*PayloadWidth +: PayloadWidth]),
      .err_stable_o (err_stable_o[k]),
      .err_drop_o   (err_drop_o[k]),
      .err_timeout_o(err_timeout_o[k]),
      .err_det_o    (det[k])
    );
  end

  logic          first_vld_q, first_vld_d;
  logic [IW-1:0] first_idx_q, first_idx_d, low_idx;

  always_comb begin
    low_idx = '0;
    for (int k = NumChan - 1; k >= 0; k--) begin
      if (det[k]) low_idx = IW'(k);
    end
  end

  // A new error in the clear cycle re-arms the capture rather than being lost.
  always_comb begin
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;
    if (clear_i) begin
      first_vld_d = 1'b0;
      first_idx_d = '0;
    end
    if ((!first_vld_q || clear_i) && |det) begin
      first_vld_d = 1'b1;
      first_idx_d = low_idx;
    end
  end

  logic [1:0]         done, ack;
  logic [1:0][PW-1:0] pend_q, pend_d;
  logic [3:0]         err_ack_q, err_ack_d;

  assign done = {b_done_i, r_done_i};
  assign ack  = {wack_i, rack_i};

  always_comb begin
    pend_d    = pend_q;
    err_ack_d = clear_i ? 4'b0 : err_ack_q;
    for (int c = 0; c < 2; c++) begin
      if (done[c] && !ack[c]) begin
        if (pend_q[c] == PW'(MaxOutstanding))
          err_ack_d[(c == 0) ? ACK_RACK_OVF : ACK_WACK_OVF] = 1'b1;
        else
          pend_d[c] = pend_q[c] + 1'b1;
      end else if (ack[c] && !done[c]) begin
        if (pend_q[c] == '0)
          err_ack_d[(c == 0) ? ACK_RACK_UDF : ACK_WACK_UDF] = 1'b1;
        else
          pend_d[c] = pend_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
      pend_q      <= '0;
      err_ack_q   <= '0;
    end else begin
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
      pend_q      <= pend_d;
      err_ack_q   <= err_ack_d;
    end
  end

  assign first_vld_o = first_vld_q;
  assign first_idx_o = first_idx_q;
  assign rack_pend_o = pend_q[0];
  assign wack_pend_o = pend_q[1];
  assign err_ack_o   = err_ack_q;

endmodule

// File: tb/tb_ace_chan_monitor.sv
// Directed bench for ace_chan_monitor; timeout expectations follow ACE_CHAN_MONITOR_TIMEOUT_EN.
module tb_ace_chan_monitor;

  localparam int NC = 5;
  localparam int PL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [NC-1:0] valid, ready;
  logic [NC*PL-1:0] payload;
  logic          r_done, b_done, rack, wack;
  logic [NC-1:0] err_stable, err_drop, err_timeout;
  logic [3:0]    err_ack;
  logic [2:0]    rack_pend, wack_pend;
  logic          first_vld;
  logic [2:0]    first_idx;

  int checks = 0;
  int errors = 0;

`ifdef ACE_CHAN_MONITOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ace_chan_monitor #(
    .NumChan(NC), .PayloadWidth(PL), .MaxOutstanding(4), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .valid_i(valid), .ready_i(ready), .payload_i(payload),
    .r_done_i(r_done), .b_done_i(b_done), .rack_i(rack), .wack_i(wack),
    .err_stable_o(err_stable), .err_drop_o(err_drop), .err_timeout_o(err_timeout),
    .err_ack_o(err_ack), .rack_pend_o(rack_pend), .wack_pend_o(wack_pend),
    .first_vld_o(first_vld), .first_idx_o(first_idx)
  );

  // Inputs change just after a falling edge; outputs are sampled at the falling edge.
  task automatic idle();
    clear = 0; valid = '0; ready = '0; payload = '0;
    r_done = 0; b_done = 0; rack = 0; wack = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1; cyc(1); clear = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; cyc(2); rst_n = 1; cyc(2);
    checks++;
    if ({err_stable, err_drop, err_timeout, err_ack, rack_pend, wack_pend, first_vld, first_idx} !== '0) begin
      errors++; $display("FAIL reset_state: got %h required 0",
        {err_stable, err_drop, err_timeout, err_ack, rack_pend, wack_pend, first_vld, first_idx});
    end
  endtask

  task automatic test_stable();
    valid[1] = 1; payload[1*PL +: PL] = 8'hA5; cyc(1);
    payload[1*PL +: PL] = 8'h5A; cyc(1);
    checks++;
    if (err_stable !== 5'b00010) begin errors++; $display("FAIL stable_ch1: got %b required 00010", err_stable); end
    checks++;
    if (first_vld !== 1'b1 || first_idx !== 3'd1) begin
      errors++; $display("FAIL first_ch1: got vld=%b idx=%0d required vld=1 idx=1", first_vld, first_idx);
    end
    ready[1] = 1; cyc(1); idle(); cyc(1);
    checks++;
    if (err_drop !== '0) begin errors++; $display("FAIL no_drop_after_hs: got %b required 0", err_drop); end
    do_clear(); cyc(1);
    checks++;
    if ({err_stable, first_vld} !== '0) begin
      errors++; $display("FAIL clear_stable: got %b/%b required 0/0", err_stable, first_vld);
    end
  endtask

  task automatic test_drop();
    valid[3] = 1; cyc(3); valid[3] = 0; cyc(1);
    checks++;
    if (err_drop !== 5'b01000) begin errors++; $display("FAIL drop_ch3: got %b required 01000", err_drop); end
    checks++;
    if (first_vld !== 1'b1 || first_idx !== 3'd3 || err_stable !== '0) begin
      errors++; $display("FAIL first_ch3: got vld=%b idx=%0d stab=%b required 1/3/0", first_vld, first_idx, err_stable);
    end
    do_clear();
    valid[0] = 1; ready[0] = 1;
    for (int i = 0; i < 4; i++) begin payload[0 +: PL] = 8'(8'h10 + i); cyc(1); end
    idle(); cyc(2);
    checks++;
    if ({err_stable, err_drop, first_vld} !== '0) begin
      errors++; $display("FAIL hs_ch0_clean: got %b/%b/%b required 0", err_stable, err_drop, first_vld);
    end
  endtask

  task automatic test_timeout();
    valid[2] = 1; cyc(7);
    checks++;
    if (err_timeout !== '0) begin errors++; $display("FAIL timeout_7cyc: got %b required 0", err_timeout); end
    cyc(1);
    checks++;
    if (err_timeout !== (TO_EN ? 5'b00100 : 5'b0)) begin
      errors++; $display("FAIL timeout_8cyc: got %b required %b", err_timeout, TO_EN ? 5'b00100 : 5'b0);
    end
    cyc(12);
    checks++;
    if (err_timeout !== (TO_EN ? 5'b00100 : 5'b0) || first_vld !== TO_EN) begin
      errors++; $display("FAIL timeout_20cyc: got %b vld=%b required en=%b", err_timeout, first_vld, TO_EN);
    end
    if (TO_EN) begin
      checks++;
      if (first_idx !== 3'd2) begin errors++; $display("FAIL timeout_first_idx: got %0d required 2", first_idx); end
    end
    ready[2] = 1; cyc(1); idle(); cyc(1);
    checks++;
    if ({err_stable, err_drop} !== '0) begin
      errors++; $display("FAIL timeout_side: got %b/%b required 0", err_stable, err_drop);
    end
  endtask

  task automatic test_rack();
    for (int i = 0; i < 3; i++) begin r_done = 1; cyc(1); r_done = 0; cyc(1); end
    checks++;
    if (rack_pend !== 3'd3) begin errors++; $display("FAIL rack_inc: got %0d required 3", rack_pend); end
    r_done = 1; rack = 1; cyc(1); idle(); cyc(1);
    checks++;
    if (rack_pend !== 3'd3) begin errors++; $display("FAIL rack_both: got %0d required 3", rack_pend); end
    for (int i = 0; i < 3; i++) begin rack = 1; cyc(1); rack = 0; cyc(1); end
    checks++;
    if (rack_pend !== 3'd0 || err_ack !== 4'b0) begin
      errors++; $display("FAIL rack_dec: got %0d ack=%b required 0/0000", rack_pend, err_ack);
    end
    rack = 1; cyc(1); rack = 0; cyc(1);
    checks++;
    if (rack_pend !== 3'd0 || err_ack !== 4'b0001) begin
      errors++; $display("FAIL rack_udf: got %0d ack=%b required 0/0001", rack_pend, err_ack);
    end
  endtask

  task automatic test_wack();
    for (int i = 0; i < 5; i++) begin b_done = 1; cyc(1); b_done = 0; cyc(1); end
    checks++;
    if (wack_pend !== 3'd4 || err_ack !== 4'b1001) begin
      errors++; $display("FAIL wack_ovf: got %0d ack=%b required 4/1001", wack_pend, err_ack);
    end
  endtask

  task automatic test_clear_precedence();
    valid[4] = 1; payload[4*PL +: PL] = 8'h11; cyc(1);
    payload[4*PL +: PL] = 8'h22; clear = 1; cyc(1); clear = 0;
    checks++;
    if (err_stable !== 5'b10000 || err_ack !== 4'b0 || err_timeout !== '0 || err_drop !== '0) begin
      errors++; $display("FAIL clear_vs_set: got stab=%b ack=%b to=%b drop=%b required 10000/0/0/0",
        err_stable, err_ack, err_timeout, err_drop);
    end
    checks++;
    if (first_vld !== 1'b1 || first_idx !== 3'd4) begin
      errors++; $display("FAIL clear_first: got vld=%b idx=%0d required 1/4", first_vld, first_idx);
    end
    checks++;
    if (wack_pend !== 3'd4) begin errors++; $display("FAIL clear_keeps_cnt: got %0d required 4", wack_pend); end
    ready[4] = 1; cyc(1); idle();
  endtask

  task automatic test_reset_mid();
    valid[0] = 1; r_done = 1; cyc(1); r_done = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({err_stable, err_drop, err_timeout, err_ack, rack_pend, wack_pend, first_vld, first_idx} !== '0) begin
      errors++; $display("FAIL async_reset: got %h required 0",
        {err_stable, err_drop, err_timeout, err_ack, rack_pend, wack_pend, first_vld, first_idx});
    end
    idle(); cyc(2); rst_n = 1; cyc(3);
    checks++;
    if ({err_stable, err_drop, first_vld, rack_pend} !== '0) begin
      errors++; $display("FAIL post_reset_quiet: got %b/%b/%b/%0d required 0",
        err_stable, err_drop, first_vld, rack_pend);
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_drop();
    test_timeout();
    test_rack();
    test_wack();
    test_clear_precedence();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ace_chan_monitor.md
ACE_CHAN_MONITOR -- requirements
Module: ace_chan_monitor

Interface
REQ-001 SHALL have parameter NumChan, default 5, the number of valid/ready channels monitored (AW, W, B, AR, R order by convention).
REQ-002 SHALL have parameter PayloadWidth, default 64, the per-channel payload width checked for stability.
REQ-003 SHALL have parameter MaxOutstanding, default 16, the saturation limit of the RACK and WACK pending counters.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, the number of valid-without-ready cycles before a timeout error is flagged.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear_i, input, 1, synchronous clear of all sticky error flags.
REQ-008 SHALL have port valid_i, input, NumChan, per-channel valid.
REQ-009 SHALL have port ready_i, input, NumChan, per-channel ready.
REQ-010 SHALL have port payload_i, input, NumChan*PayloadWidth, per-channel payload; channel k occupies bits [k*PayloadWidth +: PayloadWidth].
REQ-011 SHALL have ports r_done_i and b_done_i, input, 1 each, pulses on an R last-beat handshake and a B handshake.
REQ-012 SHALL have ports rack_i and wack_i, input, 1 each, ACE read and write acknowledge pulses.
REQ-013 SHALL have ports err_stable_o, err_drop_o and err_timeout_o, output, NumChan each, sticky per-channel errors.
REQ-014 SHALL have port err_ack_o, output, 4, sticky errors: [0] RACK underflow, [1] RACK overflow, [2] WACK underflow, [3] WACK overflow.
REQ-015 SHALL have ports rack_pend_o and wack_pend_o, output, $clog2(MaxOutstanding+1) each, the pending acknowledge counts.
REQ-016 SHALL have ports first_vld_o, output, 1, and first_idx_o, output, $clog2(NumChan), giving the channel of the first per-channel error.

Function
REQ-017 SHALL register valid, ready and payload for each channel every cycle; all checks compare the current inputs against the registered values.
REQ-018 SHALL set err_stable_o[k] one cycle after a cycle where the previous cycle had valid=1 and ready=0, the current valid=1, and the payload differs.
REQ-019 SHALL set err_drop_o[k] one cycle after a cycle where the previous cycle had valid=1 and ready=0 and the current valid=0.
REQ-020 SHALL increment a per-channel wait counter on each valid&&!ready cycle, clear it on a handshake or on !valid, and saturate it at TimeoutCycles.
REQ-021 SHALL set err_timeout_o[k] on the cycle the wait counter reaches TimeoutCycles.
REQ-022 SHALL change the RACK pending count by +1 on r_done_i alone, by -1 on rack_i alone, and leave it unchanged when both occur in the same cycle; WACK uses b_done_i/wack_i identically.
REQ-023 SHALL set the underflow bit and hold the count at 0 on an acknowledge alone while the count is 0.
REQ-024 SHALL set the overflow bit and hold the count at MaxOutstanding on a done alone while the count is MaxOutstanding.
REQ-025 SHALL clear all sticky flags with clear_i, except that an error detected in the same cycle wins and its flag remains set; clear_i does not affect the counters.
REQ-026 SHALL, when first_vld_o=0 and any per-channel error sets, capture first_vld_o=1 with the lowest erroring channel index; first_vld_o is cleared only by clear_i under the same precedence.
REQ-027 SHALL drive all outputs from registers, so that no combinational path exists from any input to any output.

Reset
REQ-028 SHALL reset all flags, counters, first_vld_o, first_idx_o and registered samples to 0; registered valid=0 prevents false errors on the first cycle after reset.
REQ-029 SHALL discard all in-progress tracking on a reset asserted mid-operation, with no error raised for it.

Configuration
REQ-030 SHALL, with ACE_CHAN_MONITOR_TIMEOUT_EN defined, implement the wait counters and err_timeout_o; without it, err_timeout_o SHALL be tied to 0 and no wait counters SHALL exist.

Structure
REQ-031 SHALL place the err_ack_o bit-index constants and the pending-count width function in ace_pkg.
REQ-032 SHALL implement the per-channel stability, drop and timeout logic as sub-module ace_hs_chk, instantiated NumChan times in a generate loop.

Verification
REQ-033 SHALL cover: ch1 valid=1, ready=0, payload 0xA5 then 0x5A the next cycle -> err_stable_o=5'b00010 one cycle later, first_idx_o=1.
REQ-034 SHALL cover: ch3 valid held 3 cycles with ready=0, then valid=0 -> err_drop_o[3]=1; ch0 handshake with payload changing every cycle -> no error.
REQ-035 SHALL cover: TimeoutCycles=8 and ch2 valid=1, ready=0 for 8 cycles -> err_timeout_o[2]=1 (macro defined); 20 cycles with the macro undefined -> 0.
REQ-036 SHALL cover: three r_done_i pulses, then rack_i together with r_done_i, then three rack_i pulses -> rack_pend_o 3,3,0; a fourth rack_i -> err_ack_o[0]=1 and count 0.
REQ-037 SHALL cover: MaxOutstanding=4 and five b_done_i pulses -> wack_pend_o=4, err_ack_o[3]=1.
REQ-038 SHALL cover: clear_i in the same cycle as a new ch4 stable error -> err_stable_o[4] stays 1 while other flags clear; async reset mid-test -> all outputs 0 immediately.
